// File: rtl/heap_pq_pkg.sv
// heap_pq shared definitions: command encoding and sift FSM states.
// Optional REPLACE command is enabled with HEAP_REPLACE_EN.
package heap_pq_pkg;
  localparam logic [1:0] OP_PUSH    = 2'b00;
  localparam logic [1:0] OP_POP     = 2'b01;
  localparam logic [1:0] OP_CLEAR   = 2'b10;
  localparam logic [1:0] OP_REPLACE = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SIFT_UP,
    SIFT_DOWN,
    RESP
  } state_t;
endpackage

// File: rtl/heap_pq_cmp.sv
// Heap ordering compare: better = a strictly precedes b.
// Unsigned; equal values never count as better.
module heap_pq_cmp #(
  parameter int DATA_W   = 32,
  parameter int MIN_HEAP = 0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              better
);
  assign better = (MIN_HEAP != 0) ? (a < b) : (a > b);
endmodule

// File: rtl/heap_pq.sv
// Binary-heap priority queue with a one-level-per-cycle sift FSM.
// Define HEAP_REPLACE_EN to enable the single-pass REPLACE command.
module heap_pq
  import heap_pq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int MIN_HEAP = 0,
  localparam int CW = $clog2(DEPTH+1),
  localparam int IW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [CW-1:0]     count,
  output logic              empty,
  output logic              full,
  output logic [DATA_W-1:0] top_data
);
  state_t state, state_nx;

  logic [DATA_W-1:0] arr [DEPTH];
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     last;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     pidx;
  logic [CW:0]       lc, rc, cidx;
  logic              l_ok, r_ok;
  logic [DATA_W-1:0] lv, rv, cv, iv;
  logic [DATA_W-1:0] rsp_q;
  logic              err_q;
  logic              up_b, r_b, c_b;
  logic              sel_r, dn_b;
  logic              accept, push_ok, pop_ok;
  logic              rep_ok, clr;

  assign last = cnt - CW'(1);
  assign pidx = (idx - IW'(1)) >> 1;
  assign lc   = (CW+1)'({idx, 1'b1});
  assign rc   = lc + (CW+1)'(1);
  assign l_ok = lc < {1'b0, cnt};
  assign r_ok = rc < {1'b0, cnt};
  assign iv   = arr[idx];
  assign lv   = arr[lc[IW-1:0]];
  assign rv   = arr[rc[IW-1:0]];

  heap_pq_cmp #(.DATA_W(DATA_W), .MIN_HEAP(MIN_HEAP)) u_up (
    .a(iv), .b(arr[pidx]), .better(up_b)
  );
  heap_pq_cmp #(.DATA_W(DATA_W), .MIN_HEAP(MIN_HEAP)) u_sel (
    .a(rv), .b(lv), .better(r_b)
  );
  heap_pq_cmp #(.DATA_W(DATA_W), .MIN_HEAP(MIN_HEAP)) u_dn (
    .a(cv), .b(iv), .better(c_b)
  );

  // Left child wins ties because the select compare is strict.
  assign sel_r = r_ok && r_b;
  assign cidx  = sel_r ? rc : lc;
  assign cv    = sel_r ? rv : lv;
  assign dn_b  = l_ok && c_b;

  assign cmd_ready = (state == IDLE) || (state == RESP);
  assign accept    = cmd_valid && cmd_ready;
  assign push_ok   = (cmd_op == OP_PUSH) && !full;
  assign pop_ok    = (cmd_op == OP_POP) && !empty;
  assign clr       = (cmd_op == OP_CLEAR);
`ifdef HEAP_REPLACE_EN
  assign rep_ok    = (cmd_op == OP_REPLACE) && !empty;
`else
  assign rep_ok    = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Errors and CLEAR pass through SIFT_UP at idx 0 for a uniform s = 0 latency.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, RESP: begin
        if (!accept)               state_nx = IDLE;
        else if (pop_ok || rep_ok) state_nx = SIFT_DOWN;
        else                       state_nx = SIFT_UP;
      end
      SIFT_UP:   state_nx = (idx != '0 && up_b) ? SIFT_UP : RESP;
      SIFT_DOWN: state_nx = dn_b ? SIFT_DOWN : RESP;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arr   <= '{default: '0};
      cnt   <= '0;
      idx   <= '0;
      rsp_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      rsp_q <= '0;
      err_q <= 1'b0;
      idx   <= '0;
      unique case (1'b1)
        push_ok: begin
          arr[cnt[IW-1:0]] <= cmd_data;
          cnt <= cnt + CW'(1);
          idx <= cnt[IW-1:0];
        end
        pop_ok: begin
          rsp_q  <= arr[0];
          arr[0] <= arr[last[IW-1:0]];
          cnt    <= last;
        end
        rep_ok: begin
          rsp_q  <= arr[0];
          arr[0] <= cmd_data;
        end
        clr:     cnt   <= '0;
        default: err_q <= 1'b1;
      endcase
    end else if (state == SIFT_UP) begin
      if (idx != '0 && up_b) begin
        arr[idx]  <= arr[pidx];
        arr[pidx] <= iv;
        idx       <= pidx;
      end
    end else if (state == SIFT_DOWN) begin
      if (dn_b) begin
        arr[cidx[IW-1:0]] <= iv;
        arr[idx]          <= cv;
        idx               <= cidx[IW-1:0];
      end
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_data  = rsp_valid ? rsp_q : '0;
  assign rsp_err   = rsp_valid && err_q;
  assign count     = cnt;
  assign empty     = (cnt == '0);
  assign full      = (cnt == CW'(DEPTH));
  assign top_data  = arr[0];
endmodule

// File: tb/tb_heap_pq.sv
// Bench for heap_pq: vector table, corner sequences, random vs queue model.
// Covers default max-heap and a DEPTH=4 min-heap instance.
module tb_heap_pq;
  import heap_pq_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic v1, v2;
  logic [1:0] op1, op2;
  logic [31:0] d1, d2;
  logic rdy1, rdy2, rv1, rv2, re1, re2;
  logic [31:0] rd1, rd2, top1, top2;
  logic [5:0] cnt1;
  logic [2:0] cnt2;
  logic emp1, emp2, ful1, ful2;

  heap_pq dut (
    .clk(clk), .reset(reset),
    .cmd_valid(v1), .cmd_ready(rdy1),
    .cmd_op(op1), .cmd_data(d1),
    .rsp_valid(rv1), .rsp_data(rd1), .rsp_err(re1),
    .count(cnt1), .empty(emp1), .full(ful1),
    .top_data(top1)
  );

  heap_pq #(.DATA_W(32), .DEPTH(4), .MIN_HEAP(1)) dut_min (
    .clk(clk), .reset(reset),
    .cmd_valid(v2), .cmd_ready(rdy2),
    .cmd_op(op2), .cmd_data(d2),
    .rsp_valid(rv2), .rsp_data(rd2), .rsp_err(re2),
    .count(cnt2), .empty(emp2), .full(ful2),
    .top_data(top2)
  );

  int cur = 0;
  logic m_rdy, m_rv, m_re, m_emp, m_ful;
  logic [31:0] m_rd, m_top;
  int m_cnt;
  always_comb begin
    m_rdy = cur != 0 ? rdy2 : rdy1;
    m_rv  = cur != 0 ? rv2 : rv1;
    m_re  = cur != 0 ? re2 : re1;
    m_rd  = cur != 0 ? rd2 : rd1;
    m_top = cur != 0 ? top2 : top1;
    m_emp = cur != 0 ? emp2 : emp1;
    m_ful = cur != 0 ? ful2 : ful1;
    m_cnt = cur != 0 ? int'(cnt2) : int'(cnt1);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_cmd(input int sel, input logic [1:0] op,
                        input logic [31:0] data,
                        output logic [31:0] rdata,
                        output logic err, output int lat);
    int w;
    cur = sel;
    rdata = '0;
    err = 1'b0;
    lat = -1;
    w = 0;
    @(negedge clk);
    while (!m_rdy && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!m_rdy) begin
      check("ready_timeout", 0, 1);
      return;
    end
    if (sel == 0) begin v1 = 1'b1; op1 = op; d1 = data; end
    else          begin v2 = 1'b1; op2 = op; d2 = data; end
    @(posedge clk);
    #1;
    v1 = 1'b0;
    v2 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!m_rv && lat < 40);
    if (!m_rv) begin
      check("rsp_timeout", 0, 1);
      return;
    end
    rdata = m_rd;
    err = m_re;
  endtask

  typedef struct {
    int          sel;
    logic [1:0]  op;
    logic [31:0] data;
    logic [31:0] rdata;
    logic        err;
    int          cnt;
    logic [31:0] top;
    int          lat;
  } vec_t;

  // Reference heap: plain queue, extreme found by linear scan.
  logic [31:0] q[$];

  function automatic int best_pos();
    int b = 0;
    for (int i = 1; i < q.size(); i++)
      if (q[i] > q[b]) b = i;
    return b;
  endfunction

  initial begin
    vec_t vt[18];
    logic [31:0] rd;
    logic er;
    int lat, dep, r, bp;
    logic [31:0] x, e;

    reset = 1'b1;
    v1 = 0; v2 = 0; op1 = 0; op2 = 0; d1 = 0; d2 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ready", rdy1, 1);
    check("rst_rsp_valid", rv1, 0);
    check("rst_rsp_data", rd1, 0);
    check("rst_rsp_err", re1, 0);
    check("rst_count", cnt1, 0);
    check("rst_empty", emp1, 1);
    check("rst_full", ful1, 0);
    check("rst_top", top1, 0);

    vt[0]  = '{0, OP_PUSH, 5, 0, 0, 1, 5, 1};
    vt[1]  = '{0, OP_PUSH, 9, 0, 0, 2, 9, 2};
    vt[2]  = '{0, OP_PUSH, 1, 0, 0, 3, 9, 1};
    vt[3]  = '{0, OP_PUSH, 7, 0, 0, 4, 9, 2};
    vt[4]  = '{0, OP_POP, 0, 9, 0, 3, 7, 2};
    vt[5]  = '{0, OP_POP, 0, 7, 0, 2, 5, 2};
    vt[6]  = '{0, OP_POP, 0, 5, 0, 1, 1, 1};
    vt[7]  = '{0, OP_POP, 0, 1, 0, 0, 0, 1};
    vt[8]  = '{0, OP_POP, 0, 0, 1, 0, 0, 1};
    vt[9]  = '{1, OP_PUSH, 3, 0, 0, 1, 3, 1};
    vt[10] = '{1, OP_PUSH, 3, 0, 0, 2, 3, 1};
    vt[11] = '{1, OP_PUSH, 8, 0, 0, 3, 3, 1};
    vt[12] = '{1, OP_PUSH, 2, 0, 0, 4, 2, 3};
    vt[13] = '{1, OP_PUSH, 6, 0, 1, 4, 2, 1};
    vt[14] = '{1, OP_POP, 0, 2, 0, 3, 3, 1};
    vt[15] = '{1, OP_POP, 0, 3, 0, 2, 3, 2};
    vt[16] = '{1, OP_POP, 0, 3, 0, 1, 8, 1};
    vt[17] = '{1, OP_POP, 0, 8, 0, 0, 0, 1};

    for (int i = 0; i < 18; i++) begin
      dep = vt[i].sel != 0 ? 4 : 32;
      do_cmd(vt[i].sel, vt[i].op, vt[i].data, rd, er, lat);
      check($sformatf("v%0d_rdata", i), rd, vt[i].rdata);
      check($sformatf("v%0d_err", i), er, vt[i].err);
      check($sformatf("v%0d_count", i), m_cnt, vt[i].cnt);
      check($sformatf("v%0d_lat", i), lat, vt[i].lat);
      check($sformatf("v%0d_empty", i), m_emp, vt[i].cnt == 0);
      check($sformatf("v%0d_full", i), m_ful, vt[i].cnt == dep);
      if (vt[i].cnt > 0)
        check($sformatf("v%0d_top", i), m_top, vt[i].top);
    end

    // Ascending fill: every push bubbles to the root.
    for (int i = 1; i <= 32; i++) begin
      do_cmd(0, OP_PUSH, i, rd, er, lat);
      if (i == 32) check("fill32_lat", lat, 6);
      else if (lat > 6) check("fill_lat_bound", lat, 6);
    end
    check("fill_full", ful1, 1);
    check("fill_top", top1, 32);
    check("fill_count", cnt1, 32);
    do_cmd(0, OP_PUSH, 99, rd, er, lat);
    check("push_full_err", er, 1);
    check("push_full_top", top1, 32);

    do_cmd(0, OP_CLEAR, 0, rd, er, lat);
    check("clear_lat", lat, 1);
    check("clear_count", cnt1, 0);
    check("clear_err", er, 0);

    do_cmd(0, OP_REPLACE, 4, rd, er, lat);
    check("rep_empty_err", er, 1);
    check("rep_empty_data", rd, 0);
    check("rep_empty_count", cnt1, 0);

    do_cmd(0, OP_PUSH, 9, rd, er, lat);
    do_cmd(0, OP_PUSH, 7, rd, er, lat);
    do_cmd(0, OP_PUSH, 5, rd, er, lat);
    do_cmd(0, OP_REPLACE, 6, rd, er, lat);
`ifdef HEAP_REPLACE_EN
    check("rep_data", rd, 9);
    check("rep_err", er, 0);
    check("rep_top", top1, 7);
    check("rep_lat", lat, 2);
`else
    check("rep_data", rd, 0);
    check("rep_err", er, 1);
    check("rep_top", top1, 9);
    check("rep_lat", lat, 1);
`endif
    check("rep_count", cnt1, 3);

    // Reset in the middle of a POP's SIFT_DOWN.
    do_cmd(0, OP_CLEAR, 0, rd, er, lat);
    for (int i = 1; i <= 8; i++) do_cmd(0, OP_PUSH, i, rd, er, lat);
    cur = 0;
    @(negedge clk);
    v1 = 1'b1; op1 = OP_POP; d1 = 0;
    @(posedge clk);
    #1;
    v1 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_rsp_valid", rv1, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_rsp_after", rv1, 0);
    check("abort_count", cnt1, 0);
    check("abort_ready", rdy1, 1);

    // Random traffic against the queue model.
    q.delete();
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      x = $urandom_range(0, 15);
      if (r < 50) begin
        do_cmd(0, OP_PUSH, x, rd, er, lat);
        if (q.size() < 32) begin
          q.push_back(x);
          check("rnd_push_err", er, 0);
        end else check("rnd_push_err", er, 1);
        check("rnd_push_data", rd, 0);
      end else if (r < 85) begin
        do_cmd(0, OP_POP, 0, rd, er, lat);
        if (q.size() > 0) begin
          bp = best_pos();
          e = q[bp];
          q.delete(bp);
          check("rnd_pop_err", er, 0);
        end else begin
          e = 0;
          check("rnd_pop_err", er, 1);
        end
        check("rnd_pop_data", rd, e);
      end else if (r < 90) begin
        do_cmd(0, OP_CLEAR, 0, rd, er, lat);
        q.delete();
        check("rnd_clear_err", er, 0);
      end else begin
        do_cmd(0, OP_REPLACE, x, rd, er, lat);
        e = 0;
`ifdef HEAP_REPLACE_EN
        if (q.size() > 0) begin
          bp = best_pos();
          e = q[bp];
          q.delete(bp);
          q.push_back(x);
        end
        check("rnd_rep_err", er, q.size() == 0);
`else
        check("rnd_rep_err", er, 1);
`endif
        check("rnd_rep_data", rd, e);
      end
      check("rnd_count", cnt1, q.size());
      if (lat > 6) check("rnd_lat_bound", lat, 6);
      if (q.size() > 0) check("rnd_top", top1, q[best_pos()]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
